hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 4 (range 1..255): freeze cycles after reset release.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255 (range 1..65535): maximum MEM_WAIT cycles before ERROR.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock.
REQ-004 rst_n in 1: asynchronous active-low reset.
REQ-005 ID_ReadRegNum1, ID_ReadRegNum2 in 5 each: source registers of the instruction in ID.
REQ-006 ID_uses_rs1, ID_uses_rs2 in 1 each: the instruction in ID reads that source.
REQ-007 EX_cntl_MemRead in 1; EX_WriteRegNum in 5: load in EX and its destination.
REQ-008 EX_branch_taken in 1: branch or jump resolved taken in EX.
REQ-009 MEM_cntl_MemRead, MEM_cntl_MemWrite in 1 each; dmem_ready in 1: data-memory access in MEM and its completion.
REQ-010 cntr_clear in 1: synchronous clear of the performance counters.
REQ-011 PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write out 1 each: pipeline register enables.
REQ-012 IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble out 1 each: squash or bubble insertion.
REQ-013 stall_cycles, flush_count out 32 each: saturating performance counters.
REQ-014 err_timeout out 1: sticky memory-timeout error.
REQ-015 state_o out 2: current FSM state, for debug.

Function
REQ-016 SHALL implement four states: BOOT=0, RUN=1, MEM_WAIT=2, ERROR=3.
REQ-017 Control outputs SHALL be combinational from state and inputs (same-cycle effect); counters, error, FSM state and internal counters SHALL be registered.
REQ-018 BOOT: PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write SHALL be 0; ID_EX_Bubble=1; MEM_WB_Bubble=1; IF_ID_Flush=0.
REQ-019 BOOT SHALL last exactly BOOT_CYCLES cycles after rst_n rises, then move to RUN.
REQ-020 Defaults in RUN: all enables 1, all squash/bubble outputs 0.
REQ-021 mem_stall is (MEM_cntl_MemRead|MEM_cntl_MemWrite)&!dmem_ready.
REQ-022 RUN with mem_stall SHALL freeze: all enables 0, MEM_WB_Bubble=1, other squash/bubble outputs 0.
REQ-023 RUN with mem_stall SHALL set the next state to MEM_WAIT and load wait_cnt with 1.
REQ-024 RUN, no mem_stall, EX_branch_taken: IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1.
REQ-025 load_use is EX_cntl_MemRead & EX_WriteRegNum!=0 & ((ID_uses_rs1&ID_ReadRegNum1==EX_WriteRegNum)|(ID_uses_rs2&ID_ReadRegNum2==EX_WriteRegNum)).
REQ-026 RUN, no mem_stall, no branch, load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; the stall SHALL last one cycle because the load advances to MEM.
REQ-027 RUN priority SHALL be mem_stall > branch flush > load_use; a simultaneous branch and load_use SHALL flush only, with no stall.
REQ-028 MEM_WAIT with !dmem_ready: outputs as REQ-022; wait_cnt SHALL increment.
REQ-029 MEM_WAIT with !dmem_ready and wait_cnt==MEM_TIMEOUT: next state SHALL be ERROR.
REQ-030 MEM_WAIT with dmem_ready: outputs SHALL be evaluated exactly as RUN with no mem_stall (branch or load_use apply); next state SHALL be RUN.
REQ-031 ERROR: outputs as REQ-022; err_timeout=1; SHALL remain in ERROR until reset.
REQ-032 stall_cycles SHALL increment each cycle PC_Write=0 in RUN, MEM_WAIT or ERROR.
REQ-033 flush_count SHALL increment each cycle IF_ID_Flush=1.
REQ-034 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-035 cntr_clear SHALL zero both counters and SHALL take priority over increment.
REQ-036 wait_cnt width SHALL be $clog2(MEM_TIMEOUT+1).

Reset
REQ-037 rst_n low SHALL immediately force state BOOT; boot counter, wait_cnt, stall_cycles, flush_count and err_timeout SHALL be 0.
REQ-038 Outputs during and right after reset SHALL be the BOOT values; reset during MEM_WAIT or ERROR SHALL abandon the wait and restart BOOT.

Structure
REQ-039 State encoding and RV32I opcode constants SHALL live in the shared package hzd_pkg.
REQ-040 The two performance counters SHALL be instances of one sub-module, sat_counter (32-bit, inc, clr).

Verification
REQ-041 Boot: release rst_n with BOOT_CYCLES=4 -> enables 0 for 4 cycles, RUN on cycle 5, state_o=1.
REQ-042 Load-use: EX load to x5, ID reads rs2=x5 -> exactly 1 cycle of PC_Write=0 and ID_EX_Bubble=1; stall_cycles=1.
REQ-043 Load-use to x0 -> no stall.
REQ-044 Branch plus load_use in the same cycle -> IF_ID_Flush=1, PC_Write=1; flush_count=1.
REQ-045 MEM read with dmem_ready low 3 cycles -> 3 frozen cycles, MEM_WB_Bubble=1, resume in RUN; stall_cycles +3.
REQ-046 MEM_TIMEOUT=8 and dmem_ready held low -> ERROR after 9 frozen cycles, err_timeout=1; rst_n pulse -> BOOT with counters 0.

Source files
------------

// File: rtl/hzd_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// RV32I opcodes, the control-output bundle and the load-use detector.
package hzd_pkg;

   localparam logic [1:0] ST_BOOT     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;
   localparam logic [1:0] ST_ERROR    = 2'd3;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic mem_wb_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam ctrl_t CTRL_BOOT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic       uses_rs1,
      input logic [4:0] rs1,
      input logic       uses_rs2,
      input logic [4:0] rs2
   );
      logic w_hit1;
      logic w_hit2;
      w_hit1 = uses_rs1 && (rs1 == ex_rd);
      w_hit2 = uses_rs2 && (rs2 == ex_rd);
      return ex_mem_read && (ex_rd != 5'd0) && (w_hit1 || w_hit2);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: boot freeze, memory-wait freeze with timeout,
// branch flush and load-use stall, plus stall/flush performance counters.
module hazard_control_unit
   import hzd_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ID_ReadRegNum1,
   input  logic [4:0]  ID_ReadRegNum2,
   input  logic        ID_uses_rs1,
   input  logic        ID_uses_rs2,
   input  logic        EX_cntl_MemRead,
   input  logic [4:0]  EX_WriteRegNum,
   input  logic        EX_branch_taken,
   input  logic        MEM_cntl_MemRead,
   input  logic        MEM_cntl_MemWrite,
   input  logic        dmem_ready,
   input  logic        cntr_clear,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        ID_EX_Write,
   output logic        EX_MEM_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Bubble,
   output logic        MEM_WB_Bubble,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
   output logic        err_timeout,
   output logic [1:0]  state_o
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [7:0]        r_boot_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_err;

   logic  w_mem_stall;
   logic  w_load_use;
   logic  w_boot_done;
   logic  w_wait_limit;
   logic  w_freeze;
   logic  w_stall_inc;
   ctrl_t w_ctrl;

   assign w_mem_stall  = (MEM_cntl_MemRead | MEM_cntl_MemWrite) & ~dmem_ready;
   assign w_load_use   = load_use_hazard(EX_cntl_MemRead, EX_WriteRegNum,
                                         ID_uses_rs1, ID_ReadRegNum1,
                                         ID_uses_rs2, ID_ReadRegNum2);
   assign w_boot_done  = (r_boot_cnt == 8'(BOOT_CYCLES - 1));
   assign w_wait_limit = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

   // MEM_WAIT only looks at dmem_ready: the access that caused it is still held in MEM.
   always_comb begin
      w_freeze = 1'b0;
      case (r_state)
         ST_RUN:      w_freeze = w_mem_stall;
         ST_MEM_WAIT: w_freeze = ~dmem_ready;
         ST_ERROR:    w_freeze = 1'b1;
         default:     w_freeze = 1'b0;
      endcase
   end

   always_comb begin
      w_ctrl = CTRL_RUN;
      if (r_state == ST_BOOT) begin
         w_ctrl = CTRL_BOOT;
      end else if (w_freeze) begin
         w_ctrl = CTRL_FREEZE;
      end else if (EX_branch_taken) begin
         w_ctrl.if_id_flush  = 1'b1;
         w_ctrl.id_ex_bubble = 1'b1;
      end else if (w_load_use) begin
         w_ctrl.pc_write     = 1'b0;
         w_ctrl.if_id_write  = 1'b0;
         w_ctrl.id_ex_bubble = 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_BOOT: begin
            if (w_boot_done) w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_mem_stall) w_next = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (dmem_ready)        w_next = ST_RUN;
            else if (w_wait_limit) w_next = ST_ERROR;
         end
         default: w_next = ST_ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_boot_cnt <= '0;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_BOOT) begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
         end
         if ((r_state == ST_RUN) && w_mem_stall) begin
            r_wait_cnt <= WAIT_W'(1);
         end else if ((r_state == ST_MEM_WAIT) && !dmem_ready && !w_wait_limit) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_next == ST_ERROR) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_stall_inc = (r_state != ST_BOOT) && !w_ctrl.pc_write;

   sat_counter #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_stall_inc),
      .clr   (cntr_clear),
      .count (stall_cycles)
   );

   sat_counter #(.W(32)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_ctrl.if_id_flush),
      .clr   (cntr_clear),
      .count (flush_count)
   );

   assign PC_Write      = w_ctrl.pc_write;
   assign IF_ID_Write   = w_ctrl.if_id_write;
   assign ID_EX_Write   = w_ctrl.id_ex_write;
   assign EX_MEM_Write  = w_ctrl.ex_mem_write;
   assign IF_ID_Flush   = w_ctrl.if_id_flush;
   assign ID_EX_Bubble  = w_ctrl.id_ex_bubble;
   assign MEM_WB_Bubble = w_ctrl.mem_wb_bubble;
   assign err_timeout   = r_err;
   assign state_o       = r_state;

endmodule
